// File: rtl/gnn_frame_loader_if.sv
// Stream input, gnn_top operand buses and completion flags of gnn_frame_loader.
// master: the loader itself; slave: the stream source / engine side.
interface gnn_frame_loader_if;
  logic              s_valid;
  logic signed [4:0] s_data;
  logic              s_last;
  logic              s_ready;

  logic signed [4:0] x0_node0, x1_node0, x2_node0, x3_node0;
  logic signed [4:0] x0_node1, x1_node1, x2_node1, x3_node1;
  logic signed [4:0] x0_node2, x1_node2, x2_node2, x3_node2;
  logic signed [4:0] x0_node3, x1_node3, x2_node3, x3_node3;
  logic signed [4:0] w04, w14, w24, w34, w05, w15, w25, w35;
  logic signed [4:0] w06, w16, w26, w36, w07, w17, w27, w37;
  logic signed [4:0] w48, w58, w68, w78, w49, w59, w69, w79;

  logic in_ready;
  logic out10_ready_node0, out10_ready_node1, out10_ready_node2, out10_ready_node3;
  logic out11_ready_node0, out11_ready_node1, out11_ready_node2, out11_ready_node3;
  logic frame_done, frame_err, timeout_err;

  modport master (
    input  s_valid, s_data, s_last,
    input  out10_ready_node0, out10_ready_node1, out10_ready_node2, out10_ready_node3,
    input  out11_ready_node0, out11_ready_node1, out11_ready_node2, out11_ready_node3,
    output s_ready, in_ready, frame_done, frame_err, timeout_err,
    output x0_node0, x1_node0, x2_node0, x3_node0, x0_node1, x1_node1, x2_node1, x3_node1,
    output x0_node2, x1_node2, x2_node2, x3_node2, x0_node3, x1_node3, x2_node3, x3_node3,
    output w04, w14, w24, w34, w05, w15, w25, w35, w06, w16, w26, w36, w07, w17, w27, w37,
    output w48, w58, w68, w78, w49, w59, w69, w79
  );

  modport slave (
    output s_valid, s_data, s_last,
    output out10_ready_node0, out10_ready_node1, out10_ready_node2, out10_ready_node3,
    output out11_ready_node0, out11_ready_node1, out11_ready_node2, out11_ready_node3,
    input  s_ready, in_ready, frame_done, frame_err, timeout_err,
    input  x0_node0, x1_node0, x2_node0, x3_node0, x0_node1, x1_node1, x2_node1, x3_node1,
    input  x0_node2, x1_node2, x2_node2, x3_node2, x0_node3, x1_node3, x2_node3, x3_node3,
    input  w04, w14, w24, w34, w05, w15, w25, w35, w06, w16, w26, w36, w07, w17, w27, w37,
    input  w48, w58, w68, w78, w49, w59, w69, w79
  );
endinterface

// File: rtl/gnn_frame_loader.sv
// Serial-to-parallel frame loader for gnn_top: LOAD -> RUN -> GAP sequencing.
// Optional shadow bank for loading the next frame during RUN/GAP: GNN_LOADER_DBUF_EN.
module gnn_frame_loader #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic                clk,
  input logic                rst,
  gnn_frame_loader_if.master bus
);
  localparam int unsigned NumWords = 40;
  localparam logic [7:0]  RunLast  = 8'(TIMEOUT - 1);
  localparam logic [3:0]  GapLast  = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StLoad, StRun, StGap} state_e;

  state_e            state_q, state_d;
  logic [5:0]        k_q, k_d;
  logic [7:0]        run_cnt_q, run_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic signed [4:0] live_q [NumWords];
  logic signed [4:0] live_d [NumWords];
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic              timeout_err_q, timeout_err_d;
`ifdef GNN_LOADER_DBUF_EN
  logic signed [4:0] shadow_q [NumWords];
  logic signed [4:0] shadow_d [NumWords];
  logic              shadow_full_q, shadow_full_d;
`endif

  logic s_ready, accept, last_word, misalign, all_done;

  always_comb begin
    s_ready = 1'b0;
    if (!rst) begin
`ifdef GNN_LOADER_DBUF_EN
      s_ready = (state_q == StLoad) || !shadow_full_q;
`else
      s_ready = (state_q == StLoad);
`endif
    end
  end

  assign accept    = bus.s_valid & s_ready;
  assign last_word = (k_q == 6'(NumWords - 1));
  assign misalign  = accept & (bus.s_last != last_word);
  assign all_done  = bus.out10_ready_node0 & bus.out10_ready_node1 & bus.out10_ready_node2 &
                     bus.out10_ready_node3 & bus.out11_ready_node0 & bus.out11_ready_node1 &
                     bus.out11_ready_node2 & bus.out11_ready_node3;

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    run_cnt_d     = run_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    live_d        = live_q;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = timeout_err_q;
`ifdef GNN_LOADER_DBUF_EN
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
`endif

    if (accept) begin
      if (misalign) begin
        frame_err_d = 1'b1;
        k_d         = '0;
      end else begin
`ifdef GNN_LOADER_DBUF_EN
        if (state_q == StLoad) begin
          live_d[k_q] = bus.s_data;
        end else begin
          shadow_d[k_q] = bus.s_data;
          if (last_word) shadow_full_d = 1'b1;
        end
`else
        live_d[k_q] = bus.s_data;
`endif
        k_d = last_word ? 6'd0 : k_q + 6'd1;
      end
    end

    unique case (state_q)
      StLoad: begin
        if (accept && !misalign && last_word) begin
          state_d   = StRun;
          run_cnt_d = '0;
        end
      end
      StRun: begin
        run_cnt_d = run_cnt_q + 8'd1;
        // Completion takes priority over a coincident timeout.
        if (all_done) begin
          frame_done_d = 1'b1;
          state_d      = StGap;
          gap_cnt_d    = '0;
        end else if (run_cnt_q == RunLast) begin
          timeout_err_d = 1'b1;
          state_d       = StGap;
          gap_cnt_d     = '0;
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q + 4'd1;
        if (gap_cnt_q == GapLast) begin
`ifdef GNN_LOADER_DBUF_EN
          if (shadow_full_d) begin
            live_d        = shadow_d;
            shadow_full_d = 1'b0;
            state_d       = StRun;
            run_cnt_d     = '0;
            k_d           = '0;
          end else begin
            // Carry the words of a partial shadow frame over so LOAD can finish it in place.
            for (int i = 0; i < int'(NumWords); i++) begin
              if (i < int'(k_d)) live_d[i] = shadow_d[i];
            end
            state_d = StLoad;
          end
`else
          state_d = StLoad;
          k_d     = '0;
`endif
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StLoad;
      k_q           <= '0;
      run_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      live_q        <= '{default: '0};
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef GNN_LOADER_DBUF_EN
      shadow_q      <= '{default: '0};
      shadow_full_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      run_cnt_q     <= run_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      live_q        <= live_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
`ifdef GNN_LOADER_DBUF_EN
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
`endif
    end
  end

  assign bus.s_ready     = s_ready;
  assign bus.in_ready    = (state_q == StRun);
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.timeout_err = timeout_err_q;

  assign bus.x0_node0 = live_q[0];   assign bus.x1_node0 = live_q[1];
  assign bus.x2_node0 = live_q[2];   assign bus.x3_node0 = live_q[3];
  assign bus.x0_node1 = live_q[4];   assign bus.x1_node1 = live_q[5];
  assign bus.x2_node1 = live_q[6];   assign bus.x3_node1 = live_q[7];
  assign bus.x0_node2 = live_q[8];   assign bus.x1_node2 = live_q[9];
  assign bus.x2_node2 = live_q[10];  assign bus.x3_node2 = live_q[11];
  assign bus.x0_node3 = live_q[12];  assign bus.x1_node3 = live_q[13];
  assign bus.x2_node3 = live_q[14];  assign bus.x3_node3 = live_q[15];
  assign bus.w04      = live_q[16];  assign bus.w14      = live_q[17];
  assign bus.w24      = live_q[18];  assign bus.w34      = live_q[19];
  assign bus.w05      = live_q[20];  assign bus.w15      = live_q[21];
  assign bus.w25      = live_q[22];  assign bus.w35      = live_q[23];
  assign bus.w06      = live_q[24];  assign bus.w16      = live_q[25];
  assign bus.w26      = live_q[26];  assign bus.w36      = live_q[27];
  assign bus.w07      = live_q[28];  assign bus.w17      = live_q[29];
  assign bus.w27      = live_q[30];  assign bus.w37      = live_q[31];
  assign bus.w48      = live_q[32];  assign bus.w58      = live_q[33];
  assign bus.w68      = live_q[34];  assign bus.w78      = live_q[35];
  assign bus.w49      = live_q[36];  assign bus.w59      = live_q[37];
  assign bus.w69      = live_q[38];  assign bus.w79      = live_q[39];
endmodule
